// File: rtl/soml_pkg.sv
// soml_pkg -- shared definitions for the HQA column reader slice.
//   DW_DEF / FRAC_DEF : default element width and fractional bits (Q8.8)
//   N_ELEM            : elements per packed column bus
//   SLICE_W           : width of one element slice in a column bus
//   NORM_W / NORM_MAX : energy accumulator width and its saturation value
//   state_t           : reader FSM state encoding
package soml_pkg;

    localparam int DW_DEF   = 16;
    localparam int FRAC_DEF = 8;
    localparam int N_ELEM   = 4;
    localparam int SLICE_W  = DW_DEF;
    localparam int NORM_W   = 32;
    localparam logic [NORM_W-1:0] NORM_MAX = 32'h7FFF_FFFF;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/cmag2.sv
// cmag2 -- combinational squared magnitude of one complex element.
//   re, im : signed DW-bit real / imaginary parts
//   mag    : re*re + im*im, unsigned, 2*DW bits
// Each square is at most 2^(2*DW-2), so the sum of two always fits in
// 2*DW bits when read as unsigned.
module cmag2 #(
    parameter int DW = 16
) (
    input  logic signed [DW-1:0]   re,
    input  logic signed [DW-1:0]   im,
    output logic        [2*DW-1:0] mag
);

    logic signed [2*DW-1:0] re_x;
    logic signed [2*DW-1:0] im_x;
    logic signed [2*DW-1:0] re_sq;
    logic signed [2*DW-1:0] im_sq;

    assign re_x  = {{DW{re[DW-1]}}, re};
    assign im_x  = {{DW{im[DW-1]}}, im};
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;
    assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/hqa_col_reader.sv
// hqa_col_reader -- captures a pair of complex columns on a rise of in_ready
// and streams their 8 elements out (col0 idx0..3, then col1 idx0..3).
//   clk, rst          : clock, synchronous active-high reset
//   in_ready          : producer level; a 0->1 rise requests a capture
//   col0_r/i, col1_r/i: packed columns, element k at [4*DW-1-k*DW -: DW]
//   busy, out_valid   : high while a captured pair is streaming
//   out_ready         : consumer accept
//   out_r/i, out_col, out_idx, out_last : current element and its position
//   err_drop          : one-cycle pulse when a rise arrives mid-stream
//   dbg_state         : current FSM state
//   norm0/1, norm_valid : per-column energy, Q16.16 (macro HQA_COL_NORM_EN)
// Handshake: an element transfers on a rising clk edge where
// out_valid && out_ready; while out_valid && !out_ready every output
// field is held, and out_valid never drops before its element transfers.
module hqa_col_reader
    import soml_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_ready,
    input  logic [4*DW-1:0] col0_r,
    input  logic [4*DW-1:0] col0_i,
    input  logic [4*DW-1:0] col1_r,
    input  logic [4*DW-1:0] col1_i,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_r,
    output logic [DW-1:0]   out_i,
    output logic            out_col,
    output logic [1:0]      out_idx,
    output logic            out_last,
    output logic            err_drop,
    output state_t          dbg_state
`ifdef HQA_COL_NORM_EN
    ,
    output logic [NORM_W-1:0] norm0,
    output logic [NORM_W-1:0] norm1,
    output logic              norm_valid
`endif
);

    // Energy output is Q(2*(DW-FRAC)).(2*FRAC); FRAC must describe a real
    // fractional split of the element.
    if (FRAC < 0 || FRAC >= DW) begin : g_bad_frac
        $error("hqa_col_reader: FRAC must lie in [0, DW)");
    end

    state_t          state_q, state_d;
    logic            in_ready_q;
    logic            rise;
    logic            capture;
    logic            accept;
    logic            last_elem;
    logic [2:0]      cnt_q;
    logic [4*DW-1:0] c0r_q, c0i_q, c1r_q, c1i_q;
    logic [DW-1:0]   c0r_a [N_ELEM];
    logic [DW-1:0]   c0i_a [N_ELEM];
    logic [DW-1:0]   c1r_a [N_ELEM];
    logic [DW-1:0]   c1i_a [N_ELEM];

    assign rise      = in_ready && !in_ready_q;
    assign capture   = (state_q == ST_IDLE) && rise;
    assign accept    = out_valid && out_ready;
    assign last_elem = (cnt_q == 3'd7);

    // Element 0 sits in the MSB slice of each column bus.
    for (genvar k = 0; k < N_ELEM; k++) begin : g_unpack
        assign c0r_a[k] = c0r_q[4*DW-1-k*DW -: DW];
        assign c0i_a[k] = c0i_q[4*DW-1-k*DW -: DW];
        assign c1r_a[k] = c1r_q[4*DW-1-k*DW -: DW];
        assign c1i_a[k] = c1i_q[4*DW-1-k*DW -: DW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            cnt_q      <= 3'd0;
            err_drop   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready;
            // A rise that lands while streaming (including on the final
            // accept) is refused; the held data is never overwritten.
            err_drop   <= rise && (state_q == ST_STREAM);
            if (capture) begin
                cnt_q <= 3'd0;
            end else if (accept) begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    // Holding registers need no reset: outputs are forced to zero whenever
    // out_valid is low, and they are always loaded before a stream starts.
    always_ff @(posedge clk) begin
        if (capture) begin
            c0r_q <= col0_r;
            c0i_q <= col0_i;
            c1r_q <= col1_r;
            c1i_q <= col1_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (rise) state_d = ST_STREAM;
            ST_STREAM: if (accept && last_elem) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_STREAM);
        busy      = out_valid;
        out_r     = '0;
        out_i     = '0;
        out_col   = 1'b0;
        out_idx   = 2'd0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_col  = cnt_q[2];
            out_idx  = cnt_q[1:0];
            out_last = last_elem;
            out_r    = cnt_q[2] ? c1r_a[cnt_q[1:0]] : c0r_a[cnt_q[1:0]];
            out_i    = cnt_q[2] ? c1i_a[cnt_q[1:0]] : c0i_a[cnt_q[1:0]];
        end
    end

    assign dbg_state = state_q;

`ifdef HQA_COL_NORM_EN
    logic [2*DW-1:0]   mag;
    logic [NORM_W-1:0] acc_sel;
    logic [NORM_W:0]   acc_sum;
    logic [NORM_W-1:0] acc_sat;

    cmag2 #(.DW(DW)) u_cmag2 (
        .re  (out_r),
        .im  (out_i),
        .mag (mag)
    );

    // One extra sum bit catches any overflow before the clamp.
    assign acc_sel = out_col ? norm1 : norm0;
    assign acc_sum = {1'b0, acc_sel} + (NORM_W+1)'(mag);
    assign acc_sat = (acc_sum > {1'b0, NORM_MAX}) ? NORM_MAX : acc_sum[NORM_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            norm0      <= '0;
            norm1      <= '0;
            norm_valid <= 1'b0;
        end else begin
            norm_valid <= accept && last_elem;
            if (capture) begin
                norm0 <= '0;
                norm1 <= '0;
            end else if (accept) begin
                if (out_col) norm1 <= acc_sat;
                else         norm0 <= acc_sat;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hqa_col_reader.sv
// tb_hqa_col_reader -- directed self-checking bench for hqa_col_reader.
// Energy checks are compiled in when HQA_COL_NORM_EN is defined.
module tb_hqa_col_reader;
    import soml_pkg::*;

    localparam int DW = 16;

    logic            clk;
    logic            rst;
    logic            in_ready;
    logic            out_ready;
    logic [4*DW-1:0] col0_r, col0_i, col1_r, col1_i;
    logic            busy, out_valid, out_col, out_last, err_drop;
    logic [DW-1:0]   out_r, out_i;
    logic [1:0]      out_idx;
    state_t          dbg_state;
`ifdef HQA_COL_NORM_EN
    logic [NORM_W-1:0] norm0, norm1;
    logic              norm_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Expected element: {col, idx, last, r, i}
    logic [35:0] exp_q[$];
    logic [15:0] er[8];
    logic [15:0] ei[8];

    hqa_col_reader #(.DW(DW), .FRAC(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready),
        .col0_r    (col0_r),
        .col0_i    (col0_i),
        .col1_r    (col1_r),
        .col1_i    (col1_i),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_col   (out_col),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err_drop  (err_drop),
        .dbg_state (dbg_state)
`ifdef HQA_COL_NORM_EN
        ,
        .norm0      (norm0),
        .norm1      (norm1),
        .norm_valid (norm_valid)
`endif
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] obs();
        return {out_col, out_idx, out_last, out_r, out_i};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, input logic [63:0] d);
        col0_r = a;
        col0_i = b;
        col1_r = c;
        col1_i = d;
    endtask

    task automatic push8();
        for (int k = 0; k < 8; k++) begin
            logic [2:0] kk;
            kk = 3'(k);
            exp_q.push_back({kk[2], kk[1:0], (kk == 3'd7), er[k], ei[k]});
        end
    endtask

    // Expects in_ready to be driven high (with in_ready low on the previous
    // edge) just before the call; the first step is the capture edge.
    task automatic run_stream(input string tag, input int stall_a, input int stall_b,
                              input int drop_cyc, input bit hold,
                              input int exp_cycles, input int exp_drops);
        int          cyc;
        int          drops;
        bit          stalled;
        logic [35:0] snap;
        logic [35:0] e;
`ifdef HQA_COL_NORM_EN
        int          nv;
        bit          nv_end;
        nv = 0;
`endif
        cyc     = 0;
        drops   = 0;
        stalled = 1'b0;
        snap    = '0;
        step();
        while (cyc < 40) begin
            if (err_drop) drops++;
`ifdef HQA_COL_NORM_EN
            if (norm_valid) nv++;
`endif
            if (!out_valid) break;
            if (stalled) check_eq({tag, "_stall_hold"}, 64'(obs()), 64'(snap));
            out_ready = !(cyc == stall_a || cyc == stall_b);
            if (out_ready) begin
                check_eq({tag, "_q_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq({tag, "_elem"}, 64'(obs()), 64'(e));
                end
                stalled = 1'b0;
            end else begin
                snap    = obs();
                stalled = 1'b1;
            end
            in_ready = hold || (cyc == drop_cyc);
            if (cyc == drop_cyc) set_data(~col0_r, ~col0_i, ~col1_r, ~col1_i);
            step();
            cyc++;
        end
        out_ready = 1'b0;
        check_eq({tag, "_cycles"}, 64'(cyc), 64'(exp_cycles));
        check_eq({tag, "_busy_end"}, 64'(busy), 64'd0);
        check_eq({tag, "_drops"}, 64'(drops), 64'(exp_drops));
        check_eq({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
`ifdef HQA_COL_NORM_EN
        nv_end = norm_valid;
        check_eq({tag, "_nv_at_end"}, 64'(nv_end), 64'd1);
        check_eq({tag, "_nv_count"}, 64'(nv), 64'd1);
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_err"}, 64'(err_drop), 64'd0);
        check_eq({tag, "_fields"}, 64'(obs()), 64'd0);
        check_eq({tag, "_state"}, 64'(dbg_state), 64'(ST_IDLE));
`ifdef HQA_COL_NORM_EN
        check_eq({tag, "_nv"}, 64'(norm_valid), 64'd0);
        check_eq({tag, "_norm0"}, 64'(norm0), 64'd0);
        check_eq({tag, "_norm1"}, 64'(norm1), 64'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        in_ready  = 1'b0;
        out_ready = 1'b0;
        set_data('0, '0, '0, '0);
        repeat (3) step();
        check_idle_outputs("reset");

        // Basic stream; in_ready=1 right after reset counts as a rise.
        rst = 1'b0;
        set_data(64'h0100_0200_0300_0400, '0, '0, '0);
        er = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0, 16'h0, 16'h0, 16'h0};
        ei = '{default: 16'h0};
        push8();
        in_ready = 1'b1;
        run_stream("basic", -1, -1, -1, 1'b0, 8, 0);
        check_eq("basic_state_idle", 64'(dbg_state), 64'(ST_IDLE));

        // Backpressure on stream cycles 2 and 5.
        in_ready = 1'b0;
        step();
        set_data(64'h1111_2222_3333_4444, 64'h0001_0002_0003_0004,
                 64'h5555_6666_7777_8888, 64'hAAAA_BBBB_CCCC_DDDD);
        er = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        ei = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        push8();
        in_ready = 1'b1;
        run_stream("bp", 1, 4, -1, 1'b0, 10, 0);

        // Rise while element 3 is presented: refused, original data continues.
        in_ready = 1'b0;
        step();
        set_data(64'h0010_0020_0030_0040, '0, '0, 64'h0F00_0E00_0D00_0C00);
        er = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0};
        ei = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0F00, 16'h0E00, 16'h0D00, 16'h0C00};
        push8();
        in_ready = 1'b1;
        run_stream("drop", -1, -1, 2, 1'b0, 8, 1);

        // Rise on the final accept: refused, FSM goes idle, no new capture.
        in_ready = 1'b0;
        step();
        set_data(64'h1111_2222_3333_4444, 64'h0001_0002_0003_0004,
                 64'h5555_6666_7777_8888, 64'hAAAA_BBBB_CCCC_DDDD);
        er = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        ei = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
        push8();
        in_ready = 1'b1;
        run_stream("drop_last", -1, -1, 7, 1'b0, 8, 1);
        step();
        check_eq("drop_last_no_capture", 64'(out_valid), 64'd0);
        check_eq("drop_last_err_cleared", 64'(err_drop), 64'd0);

        // in_ready held high throughout: one capture only.
        in_ready = 1'b0;
        step();
        set_data(64'h0001_0002_0003_0004, '0, '0, '0);
        er = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0, 16'h0, 16'h0, 16'h0};
        ei = '{default: 16'h0};
        push8();
        in_ready = 1'b1;
        run_stream("hold", -1, -1, -1, 1'b1, 8, 0);
        repeat (3) step();
        check_eq("hold_no_recapture", 64'(out_valid), 64'd0);
        in_ready = 1'b0;

        // Mid-stream reset while element 4 (col1 idx0) is presented.
        step();
        set_data(64'h0101_0202_0303_0404, 64'h0505_0606_0707_0808, '0, '0);
        in_ready = 1'b1;
        step();
        in_ready  = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check_eq("mid_rst_pos", 64'({out_col, out_idx}), 64'h4);
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        step();
        set_data('0, '0, 64'h7FFF_8000_0001_FFFF, '0);
        er = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
        ei = '{default: 16'h0};
        push8();
        in_ready = 1'b1;
        run_stream("after_rst", -1, -1, -1, 1'b0, 8, 0);

`ifdef HQA_COL_NORM_EN
        // 1.0 + 1.0j in every col0 element: 4 * 2.0 = 8.0 in Q16.16.
        in_ready = 1'b0;
        step();
        set_data(64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, '0, '0);
        er = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0};
        ei = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0};
        push8();
        in_ready = 1'b1;
        run_stream("norm", -1, -1, -1, 1'b0, 8, 0);
        check_eq("norm0", 64'(norm0), 64'h0008_0000);
        check_eq("norm1", 64'(norm1), 64'h0);

        // Most-negative parts: each element is 2^31, so both clamp.
        in_ready = 1'b0;
        step();
        set_data({4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}}, {4{16'h8000}});
        er = '{default: 16'h8000};
        ei = '{default: 16'h8000};
        push8();
        in_ready = 1'b1;
        run_stream("sat", -1, -1, -1, 1'b0, 8, 0);
        check_eq("sat_norm0", 64'(norm0), 64'h7FFF_FFFF);
        check_eq("sat_norm1", 64'(norm1), 64'h7FFF_FFFF);
        in_ready = 1'b0;
        repeat (2) step();
        check_eq("sat_norm0_held", 64'(norm0), 64'h7FFF_FFFF);
        check_eq("sat_nv_low", 64'(norm_valid), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hqa_col_reader.md
HQA_COL_READER -- requirements
Module: hqa_col_reader

Interface
REQ-001 SHALL have parameter DW, default 16, giving the width of one signed fixed-point element.
REQ-002 SHALL have parameter FRAC, default 8, giving the number of fractional bits (Q8.8).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_ready  input  1  producer column-pair-valid level.
REQ-006 SHALL have ports col0_r, col0_i, col1_r, col1_i  input  4*DW each  packed columns; element k is at bits [4*DW-1-k*DW -: DW], so k=0 is the MSB slice.
REQ-007 SHALL have port busy  output  1  high while a captured pair is being streamed.
REQ-008 SHALL have port out_valid  output  1  element available.
REQ-009 SHALL have port out_ready  input  1  consumer accept.
REQ-010 SHALL have ports out_r, out_i  output  DW  element real and imaginary parts.
REQ-011 SHALL have port out_col  output  1  source column (0 or 1).
REQ-012 SHALL have port out_idx  output  2  element index within the column.
REQ-013 SHALL have port out_last  output  1  high on the 8th element.
REQ-014 SHALL have port err_drop  output  1  one-cycle pulse when a capture is refused.
REQ-015 SHALL have ports norm0, norm1  output  32  per-column energy, Q16.16 (present only with the macro).
REQ-016 SHALL have port norm_valid  output  1  one-cycle pulse marking norm0/norm1 valid (present only with the macro).

Function
REQ-017 SHALL register in_ready and detect a rise as: in_ready=1 and registered previous value=0.
REQ-018 SHALL implement the FSM states IDLE and STREAM.
REQ-019 SHALL, in IDLE on a rise, capture all four column buses into holding registers, clear the element counter, and enter STREAM on that edge.
REQ-020 SHALL assert out_valid and busy from the cycle after capture until the last element is accepted.
REQ-021 SHALL emit elements in the order col0 idx0..3, then col1 idx0..3; out_col = counter[2] and out_idx = counter[1:0].
REQ-022 SHALL advance the counter only when out_valid && out_ready.
REQ-023 SHALL hold out_r, out_i, out_col, out_idx and out_last stable while out_valid && !out_ready.
REQ-024 SHALL return to IDLE on the cycle the 8th element is accepted, deasserting out_valid and busy on the next cycle.
REQ-025 SHALL give a maximum throughput of 8 elements in 8 cycles with out_ready held high, and a capture-to-first-element latency of 1 cycle.
REQ-026 SHALL, on a rise during STREAM, ignore the new data, pulse err_drop for one cycle, and leave the stream undisturbed.
REQ-027 SHALL treat a rise that coincides with acceptance of the last element as dropped (err_drop=1); the FSM enters IDLE.
REQ-028 SHALL ignore in_ready held high continuously; only a new rise triggers a capture.

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, counter=0, out_valid=0, busy=0, err_drop=0, out_r=out_i=0, out_col=0, out_idx=0, out_last=0, the registered in_ready=0, norm0=norm1=0 and norm_valid=0.
REQ-030 SHALL abort a stream in progress on rst, with no partial norm_valid pulse.
REQ-031 SHALL treat in_ready=1 in the first cycle after reset as a rise.

Configuration
REQ-032 SHALL gate the energy feature with macro HQA_COL_NORM_EN.
REQ-033 SHALL, with HQA_COL_NORM_EN defined, add r*r+i*i (full 2*DW product, Q16.16) to the accumulator for out_col on each accepted element.
REQ-034 SHALL clear both accumulators on capture.
REQ-035 SHALL saturate each accumulator at 32'h7FFFFFFF.
REQ-036 SHALL pulse norm_valid on the cycle after the last element is accepted, with norm0/norm1 holding their values until the next capture.
REQ-037 SHALL, without HQA_COL_NORM_EN, omit the norm0, norm1 and norm_valid ports and all multipliers.

Structure
REQ-038 SHALL place the following in shared package soml_pkg: DW/FRAC defaults, FSM state encoding, element slice width constant, and NORM_W=32.
REQ-039 SHALL use one sub-module, cmag2, to compute the squared magnitude (combinational, DW in, 2*DW out), instantiated only under the macro.

Verification
REQ-040 SHALL cover basic stream: col0_r=64'h0100_0200_0300_0400, others 0, rise, out_ready=1 -> out_r 0100,0200,0300,0400,0,0,0,0 on 8 consecutive cycles; out_last on the 8th; busy low 1 cycle later.
REQ-041 SHALL cover backpressure: out_ready low on cycles 2 and 5 of the stream -> no element skipped or duplicated, outputs stable while stalled, total 10 cycles.
REQ-042 SHALL cover drop: second rise at element 3 with different data -> err_drop pulse of 1 cycle, stream continues with the original data.
REQ-043 SHALL cover norm (macro on): col0_r all 16'h0100, col0_i all 16'h0100, col1 zero -> norm0=32'h0008_0000, norm1=0, norm_valid one cycle after out_last is accepted.
REQ-044 SHALL cover saturation (macro on): all elements 16'h8000 on both parts -> norm0=norm1=32'h7FFFFFFF.
REQ-045 SHALL cover mid-stream reset: assert rst at element 4 -> next cycle all outputs 0; a new rise after reset streams from idx0.
